// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: counter encodings, reset and
// allocation counter values, and the mispredict counter ceiling.
package branch_predictor_pkg;

  // 2-bit direction counter states; bit 1 is the taken/not-taken prediction.
  typedef enum logic [1:0] {
    BP_CTR_SNT = 2'b00,
    BP_CTR_WNT = 2'b01,
    BP_CTR_WT  = 2'b10,
    BP_CTR_ST  = 2'b11
  } bp_ctr_e;

  // Counter value after reset, and value given to a freshly allocated entry.
  localparam logic [1:0] BP_CTR_INIT  = 2'b01;
  localparam logic [1:0] BP_CTR_ALLOC = 2'b10;

  // Mispredict counter stops here instead of wrapping.
  localparam logic [31:0] BP_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/branch_predictor_sat_ctr.sv
// bp_sat_ctr: combinational next-state for a 2-bit saturating direction counter.
// Ports:
//   ctr_in  - current counter value
//   inc     - 1: step toward strongly taken, 0: step toward strongly not-taken
//   ctr_out - next counter value (holds at 00 and 11, never wraps)
module bp_sat_ctr
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_in,
  input  logic       inc,
  output logic [1:0] ctr_out
);

  // Saturating step through SNT <-> WNT <-> WT <-> ST.
  always_comb begin
    ctr_out = ctr_in;
    if (inc) begin
      case (ctr_in)
        BP_CTR_SNT: ctr_out = BP_CTR_WNT;
        BP_CTR_WNT: ctr_out = BP_CTR_WT;
        BP_CTR_WT:  ctr_out = BP_CTR_ST;
        BP_CTR_ST:  ctr_out = BP_CTR_ST;
        default:    ctr_out = ctr_in;
      endcase
    end else begin
      case (ctr_in)
        BP_CTR_SNT: ctr_out = BP_CTR_SNT;
        BP_CTR_WNT: ctr_out = BP_CTR_SNT;
        BP_CTR_WT:  ctr_out = BP_CTR_WNT;
        BP_CTR_ST:  ctr_out = BP_CTR_WT;
        default:    ctr_out = ctr_in;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating direction counters.
// Lookup is combinational from registered tables; EX updates land on the clock edge.
// Ports:
//   clk, rst_n                       - clock (rising edge), async active-low reset
//   if_valid, if_pc                  - fetch lookup request
//   pred_taken, pred_hit, pred_target- lookup result (all zero on miss / idle)
//   upd_valid, upd_pc, upd_taken,
//   upd_target, upd_mispred          - resolved branch from EX
//   btb_flush                        - invalidate every entry on the next edge
//   mispred_cnt                      - saturating mispredict count
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic        pred_hit,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred,
  input  logic        btb_flush,
  output logic [31:0] mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [29:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_hit;
  logic                up_alloc;
  logic [1:0]          ctr_next;
  logic                unused_bits;

  assign lk_idx = if_pc[IDX_BITS+1:2];
  assign lk_tag = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign up_idx = upd_pc[IDX_BITS+1:2];
  assign up_tag = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Byte-offset and above-tag PC bits, and the low target bits, carry no information here.
  assign unused_bits = ^{if_pc, upd_pc, upd_target[1:0]};

  // Update-side tag match and allocation decision; a flush suppresses all table writes.
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_alloc = upd_valid && !btb_flush && !up_hit && upd_taken;

  bp_sat_ctr u_sat_ctr (
    .ctr_in  (ctr_q[up_idx]),
    .inc     (upd_taken),
    .ctr_out (ctr_next)
  );

  // Lookup from pre-edge state: same-cycle updates are not bypassed.
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = 32'h0000_0000;
    if (if_valid && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag)) begin
      pred_hit    = 1'b1;
      pred_taken  = ctr_q[lk_idx][1];
      pred_target = {target_q[lk_idx], 2'b00};
    end else begin
      pred_hit    = 1'b0;
      pred_taken  = 1'b0;
      pred_target = 32'h0000_0000;
    end
  end

  // Valid bits: cleared by reset or flush, set on allocation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (btb_flush) begin
      valid_q <= '0;
    end else if (up_alloc) begin
      valid_q[up_idx] <= 1'b1;
    end else begin
      valid_q <= valid_q;
    end
  end

  // Direction counters: train on a hit, seed weak-taken on allocation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= BP_CTR_INIT;
      end
    end else if (upd_valid && !btb_flush && up_hit) begin
      ctr_q[up_idx] <= ctr_next;
    end else if (up_alloc) begin
      ctr_q[up_idx] <= BP_CTR_ALLOC;
    end else begin
      ctr_q[up_idx] <= ctr_q[up_idx];
    end
  end

  // Tag and target arrays are not reset; they are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (rst_n && up_alloc) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target[31:2];
    end else if (rst_n && upd_valid && !btb_flush && up_hit && upd_taken) begin
      target_q[up_idx] <= upd_target[31:2];
    end else begin
      target_q[up_idx] <= target_q[up_idx];
    end
  end

  // Mispredict counter: counts regardless of flush, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispred_cnt <= 32'h0000_0000;
    end else if (upd_valid && upd_mispred && (mispred_cnt != BP_CNT_MAX)) begin
      mispred_cnt <= mispred_cnt + 32'h0000_0001;
    end else begin
      mispred_cnt <= mispred_cnt;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = 32'h0;
  logic        pred_taken, pred_hit;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = 32'h0;
  logic        upd_mispred = 1'b0;
  logic        btb_flush = 1'b0;
  logic [31:0] mispred_cnt;

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_hit(pred_hit), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred),
    .btb_flush(btb_flush), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  longint cnt_exp = 0;

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        um;
    logic        fl;
    logic        iv;
    logic [31:0] ipc;
    logic        eh;
    logic        et;
    logic [31:0] etgt;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: entries addressed by plain arithmetic on the PC.
  bit          m_valid [64];
  int          m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];

  function automatic vec_t mk(logic uv, logic [31:0] upc, logic ut, logic [31:0] utgt,
                              logic um, logic fl, logic iv, logic [31:0] ipc,
                              logic eh, logic et, logic [31:0] etgt);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.um = um; v.fl = fl;
    v.iv = iv; v.ipc = ipc; v.eh = eh; v.et = et; v.etgt = etgt;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut; upd_target = v.utgt;
    upd_mispred = v.um; btb_flush = v.fl; if_valid = v.iv; if_pc = v.ipc;
  endtask

  // One cycle: drive at negedge, check pre-edge outputs, then let the edge happen.
  task automatic apply(string name, vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check({name, ".hit"}, {31'b0, pred_hit}, {31'b0, v.eh});
    check({name, ".taken"}, {31'b0, pred_taken}, {31'b0, v.et});
    check({name, ".target"}, pred_target, v.etgt);
    check({name, ".cnt"}, mispred_cnt, cnt_exp[31:0]);
    if (v.uv && v.um && cnt_exp < 64'hFFFF_FFFF) cnt_exp++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i] = 1;
    end
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed rows: columns uv upc ut utgt um fl iv ipc | exp hit taken target.
    vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 0, 1, 32'h100, 0, 0, 32'h000)); // reset state
    vecs.push_back(mk(1, 32'h100, 1, 32'h200, 0, 0, 1, 32'h100, 0, 0, 32'h000)); // alloc, pre-update miss
    vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 0, 1, 32'h100, 1, 1, 32'h200)); // hit ctr=10
    vecs.push_back(mk(1, 32'h100, 0, 32'h3FC, 1, 0, 1, 32'h100, 1, 1, 32'h200)); // NT -> 01
    vecs.push_back(mk(1, 32'h100, 0, 32'h3FC, 0, 0, 1, 32'h100, 1, 0, 32'h200)); // NT -> 00
    vecs.push_back(mk(1, 32'h100, 0, 32'h3FC, 0, 0, 1, 32'h100, 1, 0, 32'h200)); // NT stays 00
    vecs.push_back(mk(1, 32'h100, 0, 32'h3FC, 0, 0, 1, 32'h100, 1, 0, 32'h200)); // NT stays 00
    vecs.push_back(mk(1, 32'h100, 1, 32'h200, 1, 0, 1, 32'h100, 1, 0, 32'h200)); // T -> 01
    vecs.push_back(mk(1, 32'h100, 1, 32'h208, 0, 0, 1, 32'h100, 1, 0, 32'h200)); // T -> 10, new tgt
    vecs.push_back(mk(1, 32'h100, 1, 32'h208, 0, 0, 1, 32'h100, 1, 1, 32'h208)); // T -> 11
    vecs.push_back(mk(1, 32'h100, 1, 32'h208, 0, 0, 1, 32'h100, 1, 1, 32'h208)); // T stays 11
    vecs.push_back(mk(1, 32'h100, 0, 32'h000, 0, 0, 1, 32'h100, 1, 1, 32'h208)); // NT -> 10
    vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 0, 1, 32'h100, 1, 1, 32'h208)); // still taken at 10
    vecs.push_back(mk(1, 32'h200, 1, 32'h300, 0, 0, 1, 32'h100, 1, 1, 32'h208)); // alias replaces
    vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 0, 1, 32'h100, 0, 0, 32'h000)); // original misses
    vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 0, 1, 32'h200, 1, 1, 32'h300)); // alias hits
    vecs.push_back(mk(1, 32'h100, 0, 32'h500, 1, 0, 1, 32'h200, 1, 1, 32'h300)); // miss & NT: no change
    vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 0, 1, 32'h200, 1, 1, 32'h300)); // entry untouched
    vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 0, 0, 32'h200, 0, 0, 32'h000)); // if_valid=0
    vecs.push_back(mk(1, 32'h140, 1, 32'h400, 0, 0, 1, 32'h140, 0, 0, 32'h000)); // same-cycle: miss
    vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 0, 1, 32'h140, 1, 1, 32'h400)); // visible next cycle
    vecs.push_back(mk(1, 32'h180, 1, 32'h500, 1, 1, 1, 32'h140, 1, 1, 32'h400)); // flush + update
    vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 0, 1, 32'h140, 0, 0, 32'h000)); // flushed
    vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 0, 1, 32'h180, 0, 0, 32'h000)); // no allocation
    vecs.push_back(mk(0, 32'h000, 0, 32'h000, 0, 0, 1, 32'h200, 0, 0, 32'h000)); // flushed

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // Saturation: preload the counter three below the ceiling.
    @(negedge clk);
    drive(idle);
    force dut.mispred_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.mispred_cnt;
    cnt_exp = 64'hFFFF_FFFD;
    for (int i = 0; i < 4; i++)
      apply($sformatf("sat%0d", i), mk(1, 32'h700, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 32'h0));
    apply("sat_hold", idle);

    // Reset asserted in the middle of an allocating, mispredicting update.
    @(negedge clk);
    drive(mk(1, 32'h140, 1, 32'h600, 1, 0, 1, 32'h140, 0, 0, 32'h0));
    #2 rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("rst.cnt", mispred_cnt, 32'h0);
    check("rst.hit", {31'b0, pred_hit}, 32'h0);
    drive(idle);
    rst_n = 1'b1;
    cnt_exp = 0;
    apply("rst_look140", mk(0, 0, 0, 0, 0, 0, 1, 32'h140, 0, 0, 32'h0));
    apply("rst_look200", mk(0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0, 32'h0));

    // Randomized traffic against the model.
    model_reset();
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] lpc, upc, utgt;
      logic uv, ut, um, fl, iv, eh, et;
      logic [31:0] etgt;
      int li, ui;
      lpc  = ($urandom & 32'hFFFF_0000) | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      upc  = ($urandom & 32'hFFFF_0000) | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      utgt = $urandom;
      uv = ($urandom_range(0, 9) < 6);
      ut = $urandom_range(0, 1);
      um = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 49) == 0);
      iv = ($urandom_range(0, 9) < 8);
      li = (lpc / 4) % 64;
      ui = (upc / 4) % 64;
      eh = iv && m_valid[li] && (m_tag[li] == (lpc / 256) % 256);
      et = eh && (m_ctr[li] >= 2);
      etgt = eh ? m_tgt[li] : 32'h0;
      apply($sformatf("rnd%0d", n), mk(uv, upc, ut, utgt, um, fl, iv, lpc, eh, et, etgt));
      if (fl) begin
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      end else if (uv) begin
        if (m_valid[ui] && m_tag[ui] == (upc / 256) % 256) begin
          m_ctr[ui] = ut ? ((m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3)
                         : ((m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0);
          if (ut) m_tgt[ui] = utgt & ~32'h3;
        end else if (ut) begin
          m_valid[ui] = 1'b1;
          m_tag[ui]   = (upc / 256) % 256;
          m_tgt[ui]   = utgt & ~32'h3;
          m_ctr[ui]   = 2;
        end
      end
    end
    apply("final", idle);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
